bin_histogram: RTL and testbench

BIN_HISTOGRAM -- requirements
Module: bin_histogram

---
 rtl/bin_histogram.sv | 209 ++++++++++++++++++++
 tb/tb_bin_histogram.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_histogram.sv
// 64-bin event histogram: two-stage increment pipeline with in-flight forwarding,
// a one-index-per-cycle clear sweep, registered readback and event bookkeeping.
module bin_histogram #(
    parameter int COUNT_W = 16
) (
    input  logic               clk100,
    input  logic               reset,
    input  logic               binned,
    input  logic [5:0]         bin_in,
    input  logic [5:0]         num_bins,
    input  logic               clear,
    input  logic               rd_req,
    input  logic [5:0]         rd_addr,
    output logic [COUNT_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               busy,
    output logic [31:0]        total,
    output logic [15:0]        dropped,
    output logic               saturated
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
    localparam logic [5:0]         LAST_IDX = 6'd63;
    localparam logic [15:0]        DROP_MAX = 16'hFFFF;

    state_t             state_q, state_d;
    logic [5:0]         nb_q, nb_d;
    logic [5:0]         sweep_q, sweep_d;
    logic               busy_q, busy_d;
    logic               s1_valid_q, s1_valid_d;
    logic [5:0]         s1_bin_q, s1_bin_d;
    logic [COUNT_W-1:0] s1_cnt_q, s1_cnt_d;
    logic               rd_valid_q, rd_valid_d;
    logic [COUNT_W-1:0] rd_data_q, rd_data_d;
    logic [31:0]        total_q, total_d;
    logic [15:0]        dropped_q, dropped_d;
    logic               sat_q, sat_d;
    logic [COUNT_W-1:0] cnt_mem_q [64];

    logic               in_clear_s;
    logic               sweep_last_s;
    logic               accept_s;
    logic               reject_s;
    logic               wr_en_s;
    logic               fwd_in_s;
    logic               fwd_rd_s;
    logic [COUNT_W-1:0] wr_val_s;
    logic               mem_we_s;
    logic [5:0]         mem_addr_s;
    logic [COUNT_W-1:0] mem_wdata_s;

    function automatic logic [COUNT_W-1:0] cnt_sat_inc(input logic [COUNT_W-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + CNT_ONE;
    endfunction

    function automatic logic [15:0] drop_sat_inc(input logic [15:0] v);
        return (v == DROP_MAX) ? DROP_MAX : v + 16'd1;
    endfunction

    assign in_clear_s   = (state_q == S_CLEAR);
    assign sweep_last_s = in_clear_s && (sweep_q == LAST_IDX);
    assign accept_s     = binned && (state_q == S_RUN) && !clear && (bin_in < nb_q);
    assign reject_s     = binned && !accept_s;
    // Stage 2 is the registered stage-1 entry; its result feeds both new captures and reads.
    assign wr_en_s      = s1_valid_q;
    assign wr_val_s     = cnt_sat_inc(s1_cnt_q);
    assign fwd_in_s     = wr_en_s && (s1_bin_q == bin_in);
    assign fwd_rd_s     = wr_en_s && (s1_bin_q == rd_addr);

    // Control FSM: clear entry, sweep progress and exit to RUN.
    always_comb begin
        state_d = state_q;
        nb_d    = nb_q;
        sweep_d = sweep_q;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (clear) begin
                    state_d = S_CLEAR;
                    nb_d    = num_bins;
                    sweep_d = 6'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_CLEAR: begin
                sweep_d = sweep_q + 6'd1;
                if (sweep_last_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            default: begin
                state_d = S_IDLE;
                sweep_d = 6'd0;
            end
        endcase
        busy_d = (state_d == S_CLEAR);
    end

    // Pipeline capture and total/dropped/saturated bookkeeping.
    always_comb begin
        s1_valid_d = accept_s;
        s1_bin_d   = s1_bin_q;
        s1_cnt_d   = s1_cnt_q;
        if (accept_s) begin
            s1_bin_d = bin_in;
            s1_cnt_d = fwd_in_s ? wr_val_s : cnt_mem_q[bin_in];
        end else begin
            s1_bin_d = s1_bin_q;
            s1_cnt_d = s1_cnt_q;
        end

        total_d   = total_q;
        dropped_d = dropped_q;
        sat_d     = sat_q;
        if (sweep_last_s) begin
            total_d   = 32'd0;
            dropped_d = 16'd0;
            sat_d     = 1'b0;
        end else begin
            total_d   = wr_en_s ? total_q + 32'd1 : total_q;
            dropped_d = reject_s ? drop_sat_inc(dropped_q) : dropped_q;
            sat_d     = sat_q | (wr_en_s && (wr_val_s == CNT_MAX));
        end
    end

    // Single counter write port shared by the sweep and the stage-2 increment.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = s1_bin_q;
        mem_wdata_s = wr_val_s;
        if (reset) begin
            mem_we_s = 1'b0;
        end else if (in_clear_s) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = sweep_q;
            mem_wdata_s = CNT_ZERO;
        end else if (wr_en_s) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Readback; a read of the bin being written this cycle sees the new value.
    always_comb begin
        rd_valid_d = rd_req;
        if (rd_req) begin
            rd_data_d = fwd_rd_s ? wr_val_s : cnt_mem_q[rd_addr];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q    <= S_IDLE;
            nb_q       <= 6'd0;
            sweep_q    <= 6'd0;
            busy_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_bin_q   <= 6'd0;
            s1_cnt_q   <= CNT_ZERO;
            rd_valid_q <= 1'b0;
            rd_data_q  <= CNT_ZERO;
            total_q    <= 32'd0;
            dropped_q  <= 16'd0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nb_q       <= nb_d;
            sweep_q    <= sweep_d;
            busy_q     <= busy_d;
            s1_valid_q <= s1_valid_d;
            s1_bin_q   <= s1_bin_d;
            s1_cnt_q   <= s1_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            total_q    <= total_d;
            dropped_q  <= dropped_d;
            sat_q      <= sat_d;
        end
    end

    // Counter storage is deliberately not reset; a clear sweep initialises it.
    always_ff @(posedge clk100) begin
        if (mem_we_s) begin
            cnt_mem_q[mem_addr_s] <= mem_wdata_s;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = busy_q;
    assign total     = total_q;
    assign dropped   = dropped_q;
    assign saturated = sat_q;

endmodule

// File: tb/tb_bin_histogram.sv
// Bench for bin_histogram: directed vector table, hand-written corner sequences and
// randomized traffic checked against an array-based event model.
module tb_bin_histogram;

    logic        clk100;
    logic        reset;
    logic        binned;
    logic [5:0]  bin_in;
    logic [5:0]  num_bins;
    logic        clear;
    logic        rd_req;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic [31:0] total;
    logic [15:0] dropped;
    logic        saturated;
    logic [3:0]  rd_data4;
    logic        rd_valid4;
    logic        busy4;
    logic [31:0] total4;
    logic [15:0] dropped4;
    logic        saturated4;

    int n_vec = 0;
    int n_err = 0;

    int unsigned m_cnt [64];
    logic [5:0]  m_nb;
    logic [31:0] m_total;
    int          m_dropped;
    bit          m_sat;

    typedef struct packed {
        logic        b;
        logic [5:0]  bin;
        logic        r;
        logic [5:0]  addr;
        logic [15:0] exp_data;
    } vec_t;

    bin_histogram #(.COUNT_W(16)) dut (
        .clk100(clk100), .reset(reset), .binned(binned), .bin_in(bin_in),
        .num_bins(num_bins), .clear(clear), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .total(total),
        .dropped(dropped), .saturated(saturated)
    );

    bin_histogram #(.COUNT_W(4)) dut4 (
        .clk100(clk100), .reset(reset), .binned(binned), .bin_in(bin_in),
        .num_bins(num_bins), .clear(clear), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data4), .rd_valid(rd_valid4), .busy(busy4), .total(total4),
        .dropped(dropped4), .saturated(saturated4)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        binned  = 1'b0;
        bin_in  = 6'd0;
        clear   = 1'b0;
        rd_req  = 1'b0;
        rd_addr = 6'd0;
    endtask

    task automatic model_clear(input logic [5:0] nb);
        for (int i = 0; i < 64; i++) m_cnt[i] = 0;
        m_nb      = nb;
        m_total   = 32'd0;
        m_dropped = 0;
        m_sat     = 1'b0;
    endtask

    // One strobe seen while the histogram is running.
    task automatic model_event(input logic b, input logic [5:0] bi);
        if (b) begin
            if (bi < m_nb) begin
                if (m_cnt[bi] < 65535) m_cnt[bi] = m_cnt[bi] + 1;
                if (m_cnt[bi] == 65535) m_sat = 1'b1;
                m_total = m_total + 32'd1;
            end else if (m_dropped < 65535) begin
                m_dropped = m_dropped + 1;
            end
        end
    endtask

    // Clear sweep with a drop, an ignored re-clear and optional reads mid-sweep.
    task automatic do_clear(input logic [5:0] nb, input bit rd_chk);
        int          busy_cnt;
        int          guard;
        logic [15:0] drop_exp;
        logic [15:0] e40;
        busy_cnt = 0;
        guard    = 0;
        drop_exp = (m_dropped < 65535) ? 16'(m_dropped + 1) : 16'hFFFF;
        e40      = 16'(m_cnt[40]);
        clear    = 1'b1;
        num_bins = nb;
        tick();
        clear    = 1'b0;
        num_bins = 6'd0;
        chk("busy_rise", {31'd0, busy}, 32'd1);
        while (busy === 1'b1 && guard < 200) begin
            binned   = (guard == 5);
            bin_in   = 6'd0;
            clear    = (guard == 20);
            num_bins = (guard == 20) ? 6'd63 : 6'd0;
            rd_req   = rd_chk && (guard == 2 || guard == 3);
            rd_addr  = (guard == 2) ? 6'd1 : 6'd40;
            tick();
            busy_cnt++;
            if (guard == 5) chk("drop_in_clear", {16'd0, dropped}, {16'd0, drop_exp});
            if (rd_chk && guard == 2) begin
                chk("clr_rd_valid", {31'd0, rd_valid}, 32'd1);
                chk("clr_rd_swept", {16'd0, rd_data}, 32'd0);
            end
            if (rd_chk && guard == 3) chk("clr_rd_unswept", {16'd0, rd_data}, {16'd0, e40});
            guard++;
        end
        set_idle();
        num_bins = 6'd0;
        chk("busy_cycles", busy_cnt, 32'd64);
        chk("clr_total", total, 32'd0);
        chk("clr_dropped", {16'd0, dropped}, 32'd0);
        chk("clr_saturated", {31'd0, saturated}, 32'd0);
        model_clear(nb);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 64; a++) begin
            rd_req  = 1'b1;
            rd_addr = 6'(a);
            tick();
            chk({tag, "_bin"}, {16'd0, rd_data}, m_cnt[a]);
        end
        rd_req = 1'b0;
    endtask

    task automatic rand_round(input logic [5:0] nb);
        logic        b;
        logic [5:0]  bi;
        logic        r;
        logic [5:0]  ra;
        logic [15:0] e;
        do_clear(nb, 1'b1);
        for (int c = 0; c < 300; c++) begin
            b  = ($urandom_range(0, 9) < 7);
            bi = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                              : 6'($urandom_range(0, int'(nb) - 1));
            r  = ($urandom_range(0, 2) == 0);
            ra = ($urandom_range(0, 1) == 0) ? bi : 6'($urandom_range(0, 63));
            e  = 16'(m_cnt[ra]);
            binned  = b;
            bin_in  = bi;
            rd_req  = r;
            rd_addr = ra;
            model_event(b, bi);
            tick();
            chk("rnd_rd_valid", {31'd0, rd_valid}, {31'd0, r});
            if (r) chk("rnd_rd_data", {16'd0, rd_data}, {16'd0, e});
        end
        set_idle();
        tick();
        tick();
        chk("rnd_total", total, m_total);
        chk("rnd_dropped", {16'd0, dropped}, m_dropped);
        chk("rnd_saturated", {31'd0, saturated}, {31'd0, m_sat});
        read_all("rnd");
    endtask

    initial begin
        vec_t tbl [10];
        tbl[0] = '{1'b1, 6'd0, 1'b0, 6'd0, 16'd0};
        tbl[1] = '{1'b1, 6'd1, 1'b0, 6'd0, 16'd0};
        tbl[2] = '{1'b1, 6'd1, 1'b0, 6'd0, 16'd0};
        tbl[3] = '{1'b1, 6'd2, 1'b0, 6'd0, 16'd0};
        tbl[4] = '{1'b1, 6'd2, 1'b0, 6'd0, 16'd0};
        tbl[5] = '{1'b1, 6'd2, 1'b1, 6'd2, 16'd2};
        tbl[6] = '{1'b0, 6'd0, 1'b1, 6'd0, 16'd1};
        tbl[7] = '{1'b0, 6'd0, 1'b1, 6'd1, 16'd2};
        tbl[8] = '{1'b0, 6'd0, 1'b1, 6'd2, 16'd3};
        tbl[9] = '{1'b0, 6'd0, 1'b0, 6'd0, 16'd0};

        set_idle();
        num_bins = 6'd0;
        reset    = 1'b1;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst_total", total, 32'd0);
        chk("rst_dropped", {16'd0, dropped}, 32'd0);
        chk("rst_saturated", {31'd0, saturated}, 32'd0);
        reset = 1'b0;
        model_clear(6'd0);
        tick();

        do_clear(6'd3, 1'b0);

        for (int i = 0; i < 10; i++) begin
            binned  = tbl[i].b;
            bin_in  = tbl[i].bin;
            rd_req  = tbl[i].r;
            rd_addr = tbl[i].addr;
            model_event(tbl[i].b, tbl[i].bin);
            tick();
            chk("tbl_rd_valid", {31'd0, rd_valid}, {31'd0, tbl[i].r});
            if (tbl[i].r) chk("tbl_rd_data", {16'd0, rd_data}, {16'd0, tbl[i].exp_data});
        end
        set_idle();
        tick();
        chk("tbl_total", total, 32'd6);

        binned = 1'b1;
        bin_in = 6'd5;
        model_event(1'b1, 6'd5);
        tick();
        set_idle();
        tick();
        tick();
        chk("oor_dropped", {16'd0, dropped}, 32'd1);
        chk("oor_total", total, 32'd6);
        rd_req  = 1'b1;
        rd_addr = 6'd5;
        tick();
        rd_req = 1'b0;
        chk("oor_bin5", {16'd0, rd_data}, 32'd0);

        rand_round(6'($urandom_range(8, 40)));
        rand_round(6'($urandom_range(41, 63)));

        do_clear(6'd3, 1'b1);
        for (int i = 0; i < 20; i++) begin
            binned = 1'b1;
            bin_in = 6'd1;
            model_event(1'b1, 6'd1);
            tick();
        end
        set_idle();
        tick();
        tick();
        chk("sat4_total", total4, 32'd20);
        chk("sat4_flag", {31'd0, saturated4}, 32'd1);
        chk("sat16_total", total, m_total);
        chk("sat16_flag", {31'd0, saturated}, 32'd0);
        rd_req  = 1'b1;
        rd_addr = 6'd1;
        tick();
        rd_req = 1'b0;
        chk("sat4_bin1", {28'd0, rd_data4}, 32'd15);
        chk("sat16_bin1", {16'd0, rd_data}, 32'd20);

        clear    = 1'b1;
        num_bins = 6'd3;
        tick();
        clear    = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("abort_rd_data", {16'd0, rd_data}, 32'd0);
        chk("abort_total", total, 32'd0);
        chk("abort_dropped", {16'd0, dropped}, 32'd0);
        chk("abort_saturated", {31'd0, saturated}, 32'd0);
        tick();
        chk("abort_busy_hold", {31'd0, busy}, 32'd0);
        binned = 1'b1;
        bin_in = 6'd0;
        tick();
        set_idle();
        tick();
        tick();
        chk("idle_dropped", {16'd0, dropped}, 32'd1);
        chk("idle_total", total, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
